// File: rtl/cnn_pkg.sv
// Shared defaults, derived sizes, weight-port constants and FSM encoding
// for the CNN streaming stages.
package cnn_pkg;
   localparam int CNN_IN_W  = 8;
   localparam int CNN_WT_W  = 8;
   localparam int CNN_OUT_W = 32;
   localparam int CNN_IMG_W = 28;
   localparam int CNN_IMG_H = 28;

   localparam int OUT_COLS = CNN_IMG_W - 2;
   localparam int OUT_ROWS = CNN_IMG_H - 2;

   localparam logic [3:0] WIDX_BIAS = 4'd9;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;
endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel, weight-write and result signals of the 3x3 convolution stage.
interface conv3x3_stream_if
   import cnn_pkg::*;
#(
   parameter int In_W  = CNN_IN_W,
   parameter int Wt_W  = CNN_WT_W,
   parameter int Out_W = CNN_OUT_W
);
   logic                    iInValid;
   logic signed [In_W-1:0]  iPixData;
   logic                    iWgtValid;
   logic [3:0]              iWgtIdx;
   logic signed [Wt_W-1:0]  iWgtData;
   logic                    oOutValid;
   logic signed [Out_W-1:0] oOutData;
   logic                    oFrameDone;
   logic                    oBusy;

   modport master (
      output iInValid, iPixData, iWgtValid, iWgtIdx, iWgtData,
      input  oOutValid, oOutData, oFrameDone, oBusy
   );

   modport slave (
      input  iInValid, iPixData, iWgtValid, iWgtIdx, iWgtData,
      output oOutValid, oOutData, oFrameDone, oBusy
   );
endinterface

// File: rtl/conv_line_buf.sv
// Two row buffers sharing one column address. Reads are combinational, so
// the old contents at col are visible before the accept edge overwrites them.
module conv_line_buf #(
   parameter int In_W  = 8,
   parameter int IMG_W = 28
) (
   input  logic                         iClk,
   input  logic                         iRsn,
   input  logic                         we,
   input  logic [$clog2(IMG_W)-1:0]     col,
   input  logic signed [In_W-1:0]       din,
   output logic signed [In_W-1:0]       lb0_q,
   output logic signed [In_W-1:0]       lb1_q
);
   logic signed [In_W-1:0] lb0 [IMG_W];
   logic signed [In_W-1:0] lb1 [IMG_W];

   assign lb0_q = lb0[col];
   assign lb1_q = lb1[col];

   // shift the column down one row on every accepted pixel
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else if (we) begin
         lb1[col] <= lb0[col];
         lb0[col] <= din;
      end
   end
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-padding convolution: line buffers feed a 3x3 window,
// a 9-tap MAC computes each sum from the shifted-plus-new window so the
// completing pixel's cycle is used, and the result is registered once.
module conv3x3_stream
   import cnn_pkg::*;
#(
   parameter int In_W  = CNN_IN_W,
   parameter int Wt_W  = CNN_WT_W,
   parameter int Out_W = CNN_OUT_W,
   parameter int IMG_W = CNN_IMG_W,
   parameter int IMG_H = CNN_IMG_H
) (
   input logic               iClk,
   input logic               iRsn,
   conv3x3_stream_if.slave   bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = In_W + Wt_W;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   state_t                  state, state_nxt;
   logic [RW-1:0]           row;
   logic [CW-1:0]           col;
   logic                    accept, last_px, emit;
   logic signed [In_W-1:0]  lb0_q, lb1_q;
   logic signed [In_W-1:0]  win [9];
   logic signed [In_W-1:0]  win_nxt [9];
   logic signed [Wt_W-1:0]  wgt [9];
   logic signed [Wt_W-1:0]  bias;
   logic [PW-1:0]           prod [9];
   logic signed [Out_W-1:0] acc;
   logic                    out_valid, frame_done;
   logic signed [Out_W-1:0] out_data;

   assign accept  = bus.iInValid;
   assign last_px = (row == ROW_LAST) && (col == COL_LAST);
   assign emit    = accept && (row >= RW'(2)) && (col >= CW'(2));

   conv_line_buf #(.In_W(In_W), .IMG_W(IMG_W)) u_lb (
      .iClk  (iClk),
      .iRsn  (iRsn),
      .we    (accept),
      .col   (col),
      .din   (bus.iPixData),
      .lb0_q (lb0_q),
      .lb1_q (lb1_q)
   );

   // frame state register
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // first pixel opens a frame, the last pixel closes it
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = last_px ? S_IDLE : S_STREAM;
   end

   // raster position of the next pixel to be accepted
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // window shifted left with the new column {r-2, r-1, r} on the right
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[r*3]   = win[r*3+1];
         win_nxt[r*3+1] = win[r*3+2];
      end
      win_nxt[2] = lb1_q;
      win_nxt[5] = lb0_q;
      win_nxt[8] = bus.iPixData;
   end

   // window register; kept across row starts, the first two columns re-prime it
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) begin
         for (int k = 0; k < 9; k++) win[k] <= '0;
      end else if (accept) begin
         for (int k = 0; k < 9; k++) win[k] <= win_nxt[k];
      end
   end

   // 9-tap MAC; operands are sign-extended to PW so the low PW product bits are exact
   always_comb begin
      acc = {{(Out_W-Wt_W){bias[Wt_W-1]}}, bias};
      for (int k = 0; k < 9; k++) begin
         prod[k] = {{In_W{wgt[k][Wt_W-1]}}, wgt[k]} *
                   {{Wt_W{win_nxt[k][In_W-1]}}, win_nxt[k]};
         acc = acc + {{(Out_W-PW){prod[k][PW-1]}}, prod[k]};
      end
   end

   // coefficient writes only between frames; a pixel in the same cycle wins
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) begin
         for (int k = 0; k < 9; k++) wgt[k] <= '0;
         bias <= '0;
      end else if (state == S_IDLE && !accept && bus.iWgtValid) begin
         if (bus.iWgtIdx == WIDX_BIAS)  bias <= bus.iWgtData;
         else if (bus.iWgtIdx < 4'd9)   wgt[bus.iWgtIdx] <= bus.iWgtData;
      end
   end

   // registered result; data holds between strobes
   always_ff @(posedge iClk or posedge iRsn) begin
      if (iRsn) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_data   <= '0;
      end else begin
         out_valid  <= emit;
         frame_done <= accept && last_px;
         if (emit) out_data <= acc;
      end
   end

   assign bus.oOutValid  = out_valid;
   assign bus.oOutData   = out_data;
   assign bus.oFrameDone = frame_done;
   assign bus.oBusy      = (state == S_STREAM);
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: table of full-frame vectors plus
// hand-written sequences for weight-write drops, mid-frame reset and
// back-to-back frames.
module tb_conv3x3_stream;
   import cnn_pkg::*;

   localparam int NO = 676;

   typedef struct {
      string name;
      int    wmode;   // 0 identity, 1 all ones, 2 all -128
      int    bias;
      int    pmode;   // 0 ramp, 1 ones, 2 -128, 3 127
      bit    gaps;
      bit    ident;   // expect pixel(i+1,j+1) else constant
      int    expc;
   } vec_t;

   logic iClk = 1'b0;
   logic iRsn = 1'b1;
   always #5 iClk = ~iClk;

   conv3x3_stream_if #(.In_W(8), .Wt_W(8), .Out_W(32)) bus ();

   conv3x3_stream dut (
      .iClk (iClk),
      .iRsn (iRsn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int q[$];
   int done_cnt, lat_err, done_err, coin_err;
   bit pend_v, pend_d, ev, ed;
   logic [15:0] lfsr = 16'hACE1;
   vec_t vecs [5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int pix(input int pm, input int r, input int c);
      case (pm)
         0:       return (r * 28 + c) % 100;
         1:       return 1;
         2:       return -128;
         default: return 127;
      endcase
   endfunction

   // output monitor: expected strobes come from the driver's own position tracking
   always begin
      @(posedge iClk);
      ev = pend_v;
      ed = pend_d;
      #1;
      if (bus.oOutValid !== ev) lat_err++;
      if (bus.oOutValid === 1'b1) q.push_back(int'(bus.oOutData));
      if (bus.oFrameDone === 1'b1) begin
         done_cnt++;
         if (bus.oOutValid !== 1'b1) coin_err++;
      end
      if (bus.oFrameDone !== ed) done_err++;
   end

   task automatic clear_mon();
      q.delete();
      done_cnt = 0;
      lat_err  = 0;
      done_err = 0;
      coin_err = 0;
   endtask

   task automatic idle();
      @(negedge iClk);
      bus.iInValid  = 1'b0;
      bus.iWgtValid = 1'b0;
      pend_v = 1'b0;
      pend_d = 1'b0;
   endtask

   task automatic wgt_wr(input int idx, input int val);
      @(negedge iClk);
      bus.iInValid  = 1'b0;
      bus.iWgtValid = 1'b1;
      bus.iWgtIdx   = 4'(idx);
      bus.iWgtData  = 8'(val);
      pend_v = 1'b0;
      pend_d = 1'b0;
   endtask

   task automatic px(input int pm, input int r, input int c, input bit wr);
      @(negedge iClk);
      bus.iInValid  = 1'b1;
      bus.iPixData  = 8'(pix(pm, r, c));
      bus.iWgtValid = wr;
      bus.iWgtIdx   = 4'd4;
      bus.iWgtData  = 8'sd5;
      pend_v = (r >= 2) && (c >= 2);
      pend_d = (r == 27) && (c == 27);
   endtask

   task automatic load(input int wm, input int b);
      for (int k = 0; k < 9; k++)
         wgt_wr(k, (wm == 0) ? ((k == 4) ? 1 : 0) : (wm == 1) ? 1 : -128);
      wgt_wr(9, b);
      idle();
   endtask

   task automatic step_lfsr();
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   endtask

   task automatic frame(input int pm, input bit gaps, input int nrows,
                        input bit wr_first, input bit mid_wr);
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < 28; c++) begin
            if (r == 14 && c == 0) chk("busy mid-frame", int'(bus.oBusy), 1);
            if (gaps) begin
               step_lfsr();
               if (lfsr[0]) begin
                  idle();
                  step_lfsr();
                  if (lfsr[0]) idle();
               end
            end
            if (mid_wr && r == 5 && c == 0) wgt_wr(4, 3);
            px(pm, r, c, wr_first && r == 0 && c == 0);
         end
      end
   endtask

   task automatic check_frame(input string nm, input int n_exp, input bit ident,
                              input int scale, input int cval);
      int first;
      int e, idx;
      first = -1;
      chk({nm, " count"}, q.size(), n_exp);
      for (int i = 0; i < q.size(); i++) begin
         idx = i % NO;
         e = ident ? scale * pix(0, idx / 26 + 1, idx % 26 + 1) : cval;
         if (q[i] != e && first < 0) first = i;
      end
      checks++;
      if (first >= 0) begin
         errors++;
         idx = first % NO;
         e = ident ? scale * pix(0, idx / 26 + 1, idx % 26 + 1) : cval;
         $display("FAIL %s value[%0d]: got %0d expected %0d", nm, first, q[first], e);
      end
      chk({nm, " frame-done pulses"}, done_cnt, n_exp / NO);
      chk({nm, " valid timing errors"}, lat_err, 0);
      chk({nm, " frame-done timing errors"}, done_err, 0);
      chk({nm, " frame-done without valid"}, coin_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"identity", 0, 0,    0, 1'b0, 1'b1, 0};
      vecs[1] = '{"sum",      1, 5,    1, 1'b0, 1'b0, 14};
      vecs[2] = '{"ext_neg",  2, -128, 2, 1'b0, 1'b0, 147328};
      vecs[3] = '{"ext_pos",  2, 0,    3, 1'b0, 1'b0, -146304};
      vecs[4] = '{"gaps",     0, 0,    0, 1'b1, 1'b1, 0};

      bus.iInValid  = 1'b0;
      bus.iPixData  = '0;
      bus.iWgtValid = 1'b0;
      bus.iWgtIdx   = '0;
      bus.iWgtData  = '0;
      pend_v = 1'b0;
      pend_d = 1'b0;
      clear_mon();
      repeat (3) @(negedge iClk);
      chk("reset oOutValid", int'(bus.oOutValid), 0);
      chk("reset oOutData", int'(bus.oOutData), 0);
      chk("reset oFrameDone", int'(bus.oFrameDone), 0);
      chk("reset oBusy", int'(bus.oBusy), 0);
      iRsn = 1'b0;
      idle();

      for (int v = 0; v < 5; v++) begin
         load(vecs[v].wmode, vecs[v].bias);
         clear_mon();
         frame(vecs[v].pmode, vecs[v].gaps, 28, 1'b0, 1'b0);
         idle();
         idle();
         check_frame(vecs[v].name, NO, vecs[v].ident, 1, vecs[v].expc);
         chk({vecs[v].name, " busy after frame"}, int'(bus.oBusy), 0);
      end

      // write inside a frame is dropped; the same write between frames lands
      load(0, 0);
      clear_mon();
      frame(0, 1'b0, 28, 1'b0, 1'b1);
      idle();
      idle();
      check_frame("stream write dropped", NO, 1'b1, 1, 0);
      wgt_wr(4, 3);
      idle();
      clear_mon();
      frame(0, 1'b0, 28, 1'b1, 1'b0);   // write with the first pixel is dropped
      idle();
      idle();
      check_frame("idle write x3", NO, 1'b1, 3, 0);

      // mid-frame reset at row 10
      load(0, 0);
      clear_mon();
      frame(0, 1'b0, 10, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) px(0, 10, c, 1'b0);
      @(negedge iClk);
      chk("pre-reset output count", q.size(), 8 * 26 + 3);
      chk("pre-reset oOutData", int'(bus.oOutData), 55);
      iRsn = 1'b1;
      bus.iInValid = 1'b0;
      pend_v = 1'b0;
      pend_d = 1'b0;
      #1;
      chk("mid reset oOutValid", int'(bus.oOutValid), 0);
      chk("mid reset oOutData", int'(bus.oOutData), 0);
      chk("mid reset oFrameDone", int'(bus.oFrameDone), 0);
      chk("mid reset oBusy", int'(bus.oBusy), 0);
      @(negedge iClk);
      iRsn = 1'b0;
      clear_mon();
      frame(0, 1'b0, 28, 1'b0, 1'b0);   // weights were cleared by reset
      idle();
      idle();
      check_frame("after reset zero weights", NO, 1'b0, 1, 0);
      load(0, 0);
      clear_mon();
      frame(0, 1'b0, 28, 1'b0, 1'b0);
      idle();
      idle();
      check_frame("after reset reload", NO, 1'b1, 1, 0);

      // two frames with no gap between them
      clear_mon();
      frame(0, 1'b0, 28, 1'b0, 1'b0);
      frame(0, 1'b0, 28, 1'b0, 1'b0);
      idle();
      idle();
      check_frame("back-to-back", 2 * NO, 1'b1, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
